// File: rtl/mem_line_arbiter_pkg.sv
// Shared types and constants for the two-requester line-memory arbiter.
// Imported by the interface, the winner picker and the top-level arbiter.
package mem_arb_pkg;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_LINE_W = 256;

   localparam logic REQ_DCACHE = 1'b0;
   localparam logic REQ_ICACHE = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } arb_state_t;

endpackage

// File: rtl/mem_line_arbiter_if.sv
// Bundle of the dcache, icache and Data_Memory handshake signals around the arbiter.
// slave is the arbiter's view; master is the surrounding CPU/memory environment.
interface mem_line_arbiter_if
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int LINE_W = DEF_LINE_W
);
   logic              r0_enable_i;
   logic              r0_write_i;
   logic [ADDR_W-1:0] r0_addr_i;
   logic [LINE_W-1:0] r0_data_i;
   logic              r0_ack_o;
   logic [LINE_W-1:0] r0_data_o;

   logic              r1_enable_i;
   logic              r1_write_i;
   logic [ADDR_W-1:0] r1_addr_i;
   logic [LINE_W-1:0] r1_data_i;
   logic              r1_ack_o;
   logic [LINE_W-1:0] r1_data_o;

   logic              mem_enable_o;
   logic              mem_write_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [LINE_W-1:0] mem_data_o;
   logic              mem_ack_i;
   logic [LINE_W-1:0] mem_data_i;

   logic              grant_o;
   logic              busy_o;

   modport slave (
      input  r0_enable_i, r0_write_i, r0_addr_i, r0_data_i,
      output r0_ack_o, r0_data_o,
      input  r1_enable_i, r1_write_i, r1_addr_i, r1_data_i,
      output r1_ack_o, r1_data_o,
      output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
      input  mem_ack_i, mem_data_i,
      output grant_o, busy_o
   );

   modport master (
      output r0_enable_i, r0_write_i, r0_addr_i, r0_data_i,
      input  r0_ack_o, r0_data_o,
      output r1_enable_i, r1_write_i, r1_addr_i, r1_data_i,
      input  r1_ack_o, r1_data_o,
      input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
      output mem_ack_i, mem_data_i,
      input  grant_o, busy_o
   );

endinterface

// File: rtl/mem_line_arbiter_pick.sv
// Combinational winner select between dcache and icache requests.
// In round-robin mode a tie goes to the requester named by rr_ptr; otherwise dcache wins.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic req_0,
   input  logic req_1,
   input  logic rr_ptr,
   input  logic rr_mode,
   output logic valid,
   output logic winner
);

   always_comb begin
      valid  = req_0 | req_1;
      winner = REQ_DCACHE;
      if (req_0 && req_1) begin
         winner = rr_mode ? rr_ptr : REQ_DCACHE;
      end else if (req_1) begin
         winner = REQ_ICACHE;
      end
   end

endmodule

// File: rtl/mem_line_arbiter.sv
// Shares one line-wide Data_Memory port between dcache (r0) and icache (r1).
// Define MEM_ARB_RR_EN for round-robin tie breaking; default is fixed r0 > r1 priority.
module mem_line_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int LINE_W = DEF_LINE_W
)
(
   input  logic clk_i,
   input  logic rst_i,
   mem_line_arbiter_if.slave bus
);

   arb_state_t        state_reg;
   logic              mem_enable_reg;
   logic              mem_write_reg;
   logic [ADDR_W-1:0] mem_addr_reg;
   logic [LINE_W-1:0] mem_data_reg;
   logic              grant_reg;
   logic              busy_reg;

   logic pick_valid;
   logic pick_winner;
   logic rr_ptr;
   logic rr_mode;

`ifdef MEM_ARB_RR_EN
   logic rr_ptr_reg;

   // Pointer names the requester that wins the next tie: the one not just granted.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_ptr_reg <= REQ_DCACHE;
      end else if (state_reg == IDLE && pick_valid) begin
         rr_ptr_reg <= ~pick_winner;
      end
   end

   assign rr_ptr  = rr_ptr_reg;
   assign rr_mode = 1'b1;
`else
   assign rr_ptr  = REQ_DCACHE;
   assign rr_mode = 1'b0;
`endif

   mem_arb_pick u_pick (
      .req_0   (bus.r0_enable_i),
      .req_1   (bus.r1_enable_i),
      .rr_ptr  (rr_ptr),
      .rr_mode (rr_mode),
      .valid   (pick_valid),
      .winner  (pick_winner)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg      <= IDLE;
         mem_enable_reg <= 1'b0;
         mem_write_reg  <= 1'b0;
         mem_addr_reg   <= '0;
         mem_data_reg   <= '0;
         grant_reg      <= REQ_DCACHE;
         busy_reg       <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (pick_valid) begin
                  state_reg      <= BUSY;
                  mem_enable_reg <= 1'b1;
                  busy_reg       <= 1'b1;
                  grant_reg      <= pick_winner;
                  mem_write_reg  <= pick_winner ? bus.r1_write_i : bus.r0_write_i;
                  mem_addr_reg   <= pick_winner ? bus.r1_addr_i  : bus.r0_addr_i;
                  mem_data_reg   <= pick_winner ? bus.r1_data_i  : bus.r0_data_i;
               end
            end
            BUSY: begin
               if (bus.mem_ack_i) begin
                  state_reg      <= DONE;
                  mem_enable_reg <= 1'b0;
               end
            end
            DONE: begin
               // One forced idle cycle so memory always sees enable fall between requests.
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end
            default: begin
               state_reg      <= IDLE;
               mem_enable_reg <= 1'b0;
               busy_reg       <= 1'b0;
            end
         endcase
      end
   end

   assign bus.mem_enable_o = mem_enable_reg;
   assign bus.mem_write_o  = mem_write_reg;
   assign bus.mem_addr_o   = mem_addr_reg;
   assign bus.mem_data_o   = mem_data_reg;
   assign bus.grant_o      = grant_reg;
   assign bus.busy_o       = busy_reg;

   assign bus.r0_ack_o  = (state_reg == BUSY) && bus.mem_ack_i && (grant_reg == REQ_DCACHE);
   assign bus.r1_ack_o  = (state_reg == BUSY) && bus.mem_ack_i && (grant_reg == REQ_ICACHE);
   assign bus.r0_data_o = bus.mem_data_i;
   assign bus.r1_data_o = bus.mem_data_i;

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Randomized self-checking bench for mem_line_arbiter against a transaction-level model.
// Build with +define+MEM_ARB_RR_EN to check the round-robin tie rule instead of fixed priority.
module tb_mem_line_arbiter;

   logic clk_i = 1'b0;
   logic rst_i;

   int n_cmp = 0;
   int n_bad = 0;
   int last_granted;

   always #5 clk_i = ~clk_i;

   mem_line_arbiter_if #(.ADDR_W(32), .LINE_W(256)) bus ();

   mem_line_arbiter #(.ADDR_W(32), .LINE_W(256)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   // Model of the arbitration rule: who wins when the given requesters are pending.
   function automatic int model_pick(input bit p0, input bit p1);
      if (p0 && p1) begin
`ifdef MEM_ARB_RR_EN
         return (last_granted == 0) ? 1 : 0;
`else
         return 0;
`endif
      end
      return p0 ? 0 : 1;
   endfunction

   function automatic logic [255:0] rand_line();
      return {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic set_req(input int idx, input logic en, input logic wr,
                          input logic [31:0] addr, input logic [255:0] data);
      if (idx == 0) begin
         bus.r0_enable_i = en; bus.r0_write_i = wr;
         bus.r0_addr_i   = addr; bus.r0_data_i = data;
      end else begin
         bus.r1_enable_i = en; bus.r1_write_i = wr;
         bus.r1_addr_i   = addr; bus.r1_data_i = data;
      end
   endtask

   task automatic drop_req(input int idx);
      if (idx == 0) bus.r0_enable_i = 1'b0;
      else          bus.r1_enable_i = 1'b0;
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      set_req(0, 1'b0, 1'b0, 32'h0, '0);
      set_req(1, 1'b0, 1'b0, 32'h0, '0);
      bus.mem_ack_i = 1'b0;
      bus.mem_data_i = '0;
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b0;
      last_granted = 1;
   endtask

   // Entered at posedge+1 with the request visible; returns at posedge+1 of the following IDLE cycle.
   task automatic service_one(input int w, input int lat, input logic [31:0] ea,
                              input logic [255:0] ed, input logic ew,
                              input logic [255:0] rline, input bit scramble);
      @(posedge clk_i); #1;
      if (bus.mem_enable_o !== 1'b1 || bus.busy_o !== 1'b1) begin
         $display("FAIL grant_start: enable=%b busy=%b expected 1/1", bus.mem_enable_o, bus.busy_o);
         n_bad++;
      end
      n_cmp++;
      if (bus.grant_o !== w[0]) begin
         $display("FAIL grant_idx: got %0d expected %0d", bus.grant_o, w);
         n_bad++;
      end
      n_cmp++;
      if (bus.mem_addr_o !== ea || bus.mem_write_o !== ew || bus.mem_data_o !== ed) begin
         $display("FAIL grant_capture: addr=%h wr=%b expected addr=%h wr=%b (data equal=%b)",
                  bus.mem_addr_o, bus.mem_write_o, ea, ew, bus.mem_data_o === ed);
         n_bad++;
      end
      n_cmp++;
      last_granted = w;
      if (scramble) begin
         if (w == 0) begin
            bus.r0_addr_i ^= 32'hC0; bus.r0_data_i = ~bus.r0_data_i; bus.r0_write_i = ~bus.r0_write_i;
         end else begin
            bus.r1_addr_i ^= 32'hC0; bus.r1_data_i = ~bus.r1_data_i; bus.r1_write_i = ~bus.r1_write_i;
         end
      end
      for (int i = 1; i < lat; i++) begin
         @(posedge clk_i); #1;
         if (bus.mem_enable_o !== 1'b1 || bus.mem_addr_o !== ea || bus.mem_write_o !== ew
             || bus.r0_ack_o !== 1'b0 || bus.r1_ack_o !== 1'b0) begin
            $display("FAIL busy_hold: cyc=%0d enable=%b addr=%h wr=%b acks=%b%b expected 1 %h %b 00",
                     i, bus.mem_enable_o, bus.mem_addr_o, bus.mem_write_o, bus.r0_ack_o, bus.r1_ack_o, ea, ew);
            n_bad++;
         end
         n_cmp++;
      end
      bus.mem_data_i = rline;
      bus.mem_ack_i  = 1'b1;
      #1;
      if (bus.r0_ack_o !== (w == 0) || bus.r1_ack_o !== (w == 1)) begin
         $display("FAIL ack_route: r0_ack=%b r1_ack=%b expected requester %0d only",
                  bus.r0_ack_o, bus.r1_ack_o, w);
         n_bad++;
      end
      n_cmp++;
      if (bus.r0_data_o !== rline || bus.r1_data_o !== rline) begin
         $display("FAIL read_line: r0_data=%h r1_data=%h expected %h", bus.r0_data_o, bus.r1_data_o, rline);
         n_bad++;
      end
      n_cmp++;
      @(posedge clk_i); #1;
      bus.mem_ack_i = 1'b0;
      drop_req(w);
      if (bus.mem_enable_o !== 1'b0 || bus.busy_o !== 1'b1) begin
         $display("FAIL done_cycle: enable=%b busy=%b expected 0/1", bus.mem_enable_o, bus.busy_o);
         n_bad++;
      end
      n_cmp++;
      @(posedge clk_i); #1;
      if (bus.mem_enable_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.grant_o !== w[0]) begin
         $display("FAIL back_to_idle: enable=%b busy=%b grant=%b expected 0/0/%0d",
                  bus.mem_enable_o, bus.busy_o, bus.grant_o, w);
         n_bad++;
      end
      n_cmp++;
      $display("txn: req=%0d addr=%h write=%b latency=%0d", w, ea, ew, lat);
   endtask

   task automatic test_reset();
      do_reset();
      if (bus.mem_enable_o !== 1'b0 || bus.mem_write_o !== 1'b0 || bus.busy_o !== 1'b0
          || bus.grant_o !== 1'b0 || bus.mem_addr_o !== 32'h0 || bus.mem_data_o !== 256'h0) begin
         $display("FAIL reset_values: en=%b wr=%b busy=%b grant=%b addr=%h expected all zero",
                  bus.mem_enable_o, bus.mem_write_o, bus.busy_o, bus.grant_o, bus.mem_addr_o);
         n_bad++;
      end
      n_cmp++;
   endtask

   task automatic test_single_read();
      logic [255:0] line;
      line = {8{32'h8888_9999}};
      set_req(0, 1'b1, 1'b0, 32'h0000_0020, '0);
      service_one(0, 10, 32'h20, 256'h0, 1'b0, line, 1'b0);
   endtask

   task automatic test_simultaneous();
      logic [255:0] wline;
      int first;
      do_reset();
      wline = rand_line();
      set_req(0, 1'b1, 1'b1, 32'h400, wline);
      set_req(1, 1'b1, 1'b0, 32'h40, '0);
      first = model_pick(1'b1, 1'b1);
      if (first == 0) begin
         service_one(0, 4, 32'h400, wline, 1'b1, rand_line(), 1'b0);
         service_one(1, 3, 32'h40, 256'h0, 1'b0, rand_line(), 1'b0);
      end else begin
         service_one(1, 3, 32'h40, 256'h0, 1'b0, rand_line(), 1'b0);
         service_one(0, 4, 32'h400, wline, 1'b1, rand_line(), 1'b0);
      end
   endtask

   task automatic test_back_to_back();
      set_req(1, 1'b1, 1'b0, 32'h100, '0);
      service_one(1, 2, 32'h100, 256'h0, 1'b0, rand_line(), 1'b0);
      set_req(1, 1'b1, 1'b0, 32'h120, '0);
      service_one(1, 1, 32'h120, 256'h0, 1'b0, rand_line(), 1'b0);
   endtask

   task automatic test_reset_mid_busy();
      logic [255:0] wline;
      wline = rand_line();
      set_req(0, 1'b1, 1'b1, 32'h0000_0800, wline);
      repeat (4) @(posedge clk_i);
      #1 rst_i = 1'b1;
      drop_req(0);
      @(posedge clk_i); #1 rst_i = 1'b0;
      last_granted = 1;
      if (bus.mem_enable_o !== 1'b0 || bus.mem_write_o !== 1'b0 || bus.busy_o !== 1'b0
          || bus.mem_addr_o !== 32'h0 || bus.mem_data_o !== 256'h0) begin
         $display("FAIL reset_mid_busy: en=%b wr=%b busy=%b addr=%h expected zeros",
                  bus.mem_enable_o, bus.mem_write_o, bus.busy_o, bus.mem_addr_o);
         n_bad++;
      end
      n_cmp++;
      bus.mem_ack_i = 1'b1;
      #1;
      if (bus.r0_ack_o !== 1'b0 || bus.r1_ack_o !== 1'b0) begin
         $display("FAIL late_ack: acks=%b%b expected 00", bus.r0_ack_o, bus.r1_ack_o);
         n_bad++;
      end
      n_cmp++;
      @(posedge clk_i); #1 bus.mem_ack_i = 1'b0;
      set_req(1, 1'b1, 1'b0, 32'h60, '0);
      service_one(1, 3, 32'h60, 256'h0, 1'b0, rand_line(), 1'b0);
   endtask

   task automatic test_stray_and_hold();
      bus.mem_ack_i = 1'b1;
      bus.mem_data_i = rand_line();
      #1;
      if (bus.r0_ack_o !== 1'b0 || bus.r1_ack_o !== 1'b0) begin
         $display("FAIL stray_ack: acks=%b%b expected 00", bus.r0_ack_o, bus.r1_ack_o);
         n_bad++;
      end
      n_cmp++;
      @(posedge clk_i); #1 bus.mem_ack_i = 1'b0;
      if (bus.busy_o !== 1'b0 || bus.mem_enable_o !== 1'b0) begin
         $display("FAIL stray_state: busy=%b enable=%b expected 0/0", bus.busy_o, bus.mem_enable_o);
         n_bad++;
      end
      n_cmp++;
      // scramble turns the icache address 0x40 into 0x80 while BUSY
      set_req(1, 1'b1, 1'b0, 32'h40, '0);
      service_one(1, 5, 32'h40, 256'h0, 1'b0, rand_line(), 1'b1);
   endtask

   task automatic test_random();
      logic [31:0]  a [2];
      logic [255:0] d [2];
      logic         wr [2];
      bit           pend [2];
      int           w;
      for (int it = 0; it < 25; it++) begin
         pend[0] = $urandom_range(0, 1);
         pend[1] = $urandom_range(0, 1);
         if (!pend[0] && !pend[1]) pend[$urandom_range(0, 1)] = 1'b1;
         for (int k = 0; k < 2; k++) begin
            a[k]  = $urandom() & 32'hFFFF_FFE0;
            d[k]  = rand_line();
            wr[k] = $urandom_range(0, 1);
            set_req(k, pend[k], wr[k], a[k], d[k]);
         end
         while (pend[0] || pend[1]) begin
            w = model_pick(pend[0], pend[1]);
            service_one(w, $urandom_range(1, 8), a[w], d[w], wr[w], rand_line(), $urandom_range(0, 1));
            pend[w] = 1'b0;
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_simultaneous();
      test_back_to_back();
      test_reset_mid_busy();
      test_stray_and_hold();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
